// File: rtl/i2si_src_fifo.sv
// i2si_src_fifo: selects deserializer or BIST words per frame strobe and buffers them as tagged L/R entries in a FWFT FIFO.
// Latency: strobe in cycle T -> left entry at head (out_vld) in T+2, right entry written at end of T+2.
// Backpressure: out_vld/out_rdy handshake; full FIFO drops pushes (sticky i2si_ovf), strobes during a pair write are dropped.
// Optional macro I2SI_OVF_CNT_EN: adds the saturating 8-bit drop counter on i2si_ovf_cnt (tied to zero otherwise).
module i2si_src_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rf_i2si_en,
  input  logic          rf_bist_en,
  input  logic          rf_ovf_clr,
  input  logic          i2si_xfc,
  input  logic [31:0]   i2si_lft,
  input  logic [31:0]   i2si_rgt,
  input  logic [31:0]   i2si_bist_out_data,
  output logic [31:0]   i2si_out_data,
  output logic          i2si_out_chan,
  output logic          i2si_out_vld,
  input  logic          i2si_out_rdy,
  output logic [AW:0]   i2si_fifo_lvl,
  output logic          i2si_ovf,
  output logic [7:0]    i2si_ovf_cnt
);

  // Occupancy value that means "every slot holds an entry".
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_L = 2'd1,
    WR_R = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // Captured frame, held while the pair is written over two cycles.
  logic [31:0]   hold_l;
  logic [31:0]   hold_r;

  // Entry storage: data word plus channel tag.
  logic [31:0]   mem_data [DEPTH];
  logic [DEPTH-1:0] mem_chan;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Decoded per-cycle actions.
  logic          capture;
  logic          push_req;
  logic          push_chan;
  logic [31:0]   push_data;
  logic          strobe_drop;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          push_drop;
  logic [1:0]    drop_n;

  // Write FSM: next state and push request; disable forces idle and suppresses all actions.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    push_req    = 1'b0;
    push_chan   = 1'b0;
    push_data   = hold_l;
    strobe_drop = 1'b0;
    case (state)
      IDLE: begin
        if (i2si_xfc) begin
          capture   = 1'b1;
          state_nxt = WR_L;
        end
      end
      WR_L: begin
        push_req    = 1'b1;
        push_chan   = 1'b0;
        push_data   = hold_l;
        strobe_drop = i2si_xfc;
        state_nxt   = WR_R;
      end
      WR_R: begin
        push_req    = 1'b1;
        push_chan   = 1'b1;
        push_data   = hold_r;
        strobe_drop = i2si_xfc;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!rf_i2si_en) begin
      state_nxt   = IDLE;
      capture     = 1'b0;
      push_req    = 1'b0;
      strobe_drop = 1'b0;
    end
  end

  // FIFO handshake decode; a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    full      = (count == FULL_LVL);
    pop       = (count != '0) && i2si_out_rdy && rf_i2si_en;
    push_ok   = push_req && (!full || pop);
    push_drop = push_req && full && !pop;
    drop_n    = {1'b0, strobe_drop} + {1'b0, push_drop};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Source select: BIST word goes to both channels, otherwise the deserialized pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l <= '0;
      hold_r <= '0;
    end else if (capture) begin
      if (rf_bist_en) begin
        hold_l <= i2si_bist_out_data;
        hold_r <= i2si_bist_out_data;
      end else begin
        hold_l <= i2si_lft;
        hold_r <= i2si_rgt;
      end
    end
  end

  // Entry storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
      end
      mem_chan <= '0;
    end else if (push_ok) begin
      mem_data[wr_ptr] <= push_data;
      mem_chan[wr_ptr] <= push_chan;
    end
  end

  // Pointers and occupancy; disable flushes without touching the stored words.
  always_ff @(posedge clk) begin
    if (rst || !rf_i2si_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop) begin
        count <= count + LVL_ONE;
      end else if (!push_ok && pop) begin
        count <= count - LVL_ONE;
      end
    end
  end

  // Sticky overflow flag; clear wins over a same-cycle drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      i2si_ovf <= 1'b0;
    end else if (rf_ovf_clr) begin
      i2si_ovf <= 1'b0;
    end else if (drop_n != 2'd0) begin
      i2si_ovf <= 1'b1;
    end
  end

`ifdef I2SI_OVF_CNT_EN
  logic [8:0] cnt_sum;
  logic [7:0] ovf_cnt_q;

  // Saturating sum of drops this cycle (a strobe drop and an entry drop can coincide).
  always_comb begin
    cnt_sum = {1'b0, ovf_cnt_q} + {7'b0, drop_n};
  end

  // Drop counter: saturates at 255, clear wins over a same-cycle drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else if (rf_ovf_clr) begin
      ovf_cnt_q <= '0;
    end else if (cnt_sum[8]) begin
      ovf_cnt_q <= 8'hFF;
    end else begin
      ovf_cnt_q <= cnt_sum[7:0];
    end
  end

  assign i2si_ovf_cnt = ovf_cnt_q;
`else
  assign i2si_ovf_cnt = 8'h00;
`endif

  // First-word-fall-through head straight from storage.
  assign i2si_out_data = mem_data[rd_ptr];
  assign i2si_out_chan = mem_chan[rd_ptr];
  assign i2si_out_vld  = (count != '0);
  assign i2si_fifo_lvl = count;

endmodule

// File: tb/tb_i2si_src_fifo.sv
// tb_i2si_src_fifo: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: model advances one clock per tick; outputs sampled 1 time unit after the rising edge.
// Backpressure: out_rdy driven directly by the scenarios and randomly in the soak test.
module tb_i2si_src_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef I2SI_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        chan;
    logic [31:0] data;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          en;
  logic          bist_en;
  logic          ovf_clr;
  logic          xfc;
  logic [31:0]   lft;
  logic [31:0]   rgt;
  logic [31:0]   bist;
  logic [31:0]   out_data;
  logic          out_chan;
  logic          out_vld;
  logic          out_rdy;
  logic [AW:0]   lvl;
  logic          ovf;
  logic [7:0]    ovf_cnt;

  int n_cmp;
  int n_err;

  // Reference model: FIFO contents, entries still waiting to be written, overflow state.
  ent_t m_q[$];
  ent_t m_pend[$];
  bit   m_ovf;
  int   m_cnt;

  i2si_src_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                (clk),
    .rst                (rst),
    .rf_i2si_en         (en),
    .rf_bist_en         (bist_en),
    .rf_ovf_clr         (ovf_clr),
    .i2si_xfc           (xfc),
    .i2si_lft           (lft),
    .i2si_rgt           (rgt),
    .i2si_bist_out_data (bist),
    .i2si_out_data      (out_data),
    .i2si_out_chan      (out_chan),
    .i2si_out_vld       (out_vld),
    .i2si_out_rdy       (out_rdy),
    .i2si_fifo_lvl      (lvl),
    .i2si_ovf           (ovf),
    .i2si_ovf_cnt       (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one clock of the behavioural rules to the model using the inputs present now.
  task automatic model_step();
    bit   do_pop;
    bit   has_push;
    bit   was_full;
    bit   was_idle;
    int   drops;
    ent_t e;
    do_pop   = (m_q.size() > 0) && out_rdy;
    has_push = (m_pend.size() > 0);
    was_full = (m_q.size() == DEPTH);
    was_idle = (m_pend.size() == 0);
    drops    = 0;
    if (en && has_push && was_full && !do_pop) drops++;
    if (en && xfc && !was_idle) drops++;
    if (rst) begin
      m_q.delete();
      m_pend.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
      return;
    end
    if (ovf_clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end else if (drops > 0) begin
      m_ovf = 1'b1;
      if (CNT_EN) m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
    end
    if (!en) begin
      m_q.delete();
      m_pend.delete();
      return;
    end
    if (do_pop) void'(m_q.pop_front());
    if (has_push) begin
      e = m_pend.pop_front();
      if (!was_full || do_pop) m_q.push_back(e);
    end
    if (xfc && was_idle) begin
      m_pend.push_back({1'b0, bist_en ? bist : lft});
      m_pend.push_back({1'b1, bist_en ? bist : rgt});
    end
  endtask

  // Advance one clock: model first (pre-edge inputs), then the DUT edge, then settle.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %0d need 0", out_vld); end
    n_cmp++; if (lvl !== 4'd0) begin n_err++; $display("FAIL reset_lvl: got %0d need 0", lvl); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0d need 0", ovf); end
    n_cmp++; if (ovf_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d need 0", ovf_cnt); end
    n_cmp++; if (out_data !== 32'd0 || out_chan !== 1'b0) begin n_err++; $display("FAIL reset_head: got %0h/%0d need 0/0", out_data, out_chan); end
  endtask

  task automatic test_deser();
    out_rdy = 1'b1;
    lft = 32'h0000_1234;
    rgt = 32'h0000_ABCD;
    xfc = 1'b1;
    tick();
    xfc = 1'b0;
    lft = 32'hDEAD_0000;
    rgt = 32'hBEEF_0000;
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL deser_vld_t1: got %0d need 0", out_vld); end
    tick();
    n_cmp++; if (out_vld !== 1'b1 || out_chan !== 1'b0 || out_data !== 32'h1234) begin
      n_err++; $display("FAIL deser_left: got vld %0d chan %0d data %0h need 1 0 1234", out_vld, out_chan, out_data); end
    tick();
    n_cmp++; if (out_vld !== 1'b1 || out_chan !== 1'b1 || out_data !== 32'hABCD) begin
      n_err++; $display("FAIL deser_right: got vld %0d chan %0d data %0h need 1 1 abcd", out_vld, out_chan, out_data); end
    tick();
    n_cmp++; if (lvl !== 4'd0 || out_vld !== 1'b0) begin n_err++; $display("FAIL deser_drain: got lvl %0d vld %0d need 0 0", lvl, out_vld); end
  endtask

  task automatic test_bist();
    out_rdy = 1'b1;
    lft = 32'h1111_1111;
    rgt = 32'h2222_2222;
    bist = 32'h0000_0100;
    bist_en = 1'b1;
    xfc = 1'b1;
    tick();
    xfc = 1'b0;
    bist_en = 1'b0;
    bist = 32'h0000_0101;
    tick();
    n_cmp++; if (out_chan !== 1'b0 || out_data !== 32'h100) begin
      n_err++; $display("FAIL bist_left: got chan %0d data %0h need 0 100", out_chan, out_data); end
    tick();
    n_cmp++; if (out_chan !== 1'b1 || out_data !== 32'h100) begin
      n_err++; $display("FAIL bist_right: got chan %0d data %0h need 1 100", out_chan, out_data); end
    tick();
  endtask

  task automatic test_overflow();
    out_rdy = 1'b0;
    for (int p = 0; p < 5; p++) begin
      lft = 32'h100 + 32'(p);
      rgt = 32'h200 + 32'(p);
      xfc = 1'b1;
      tick();
      xfc = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      if (p == 3) begin
        n_cmp++; if (lvl !== 4'd8 || ovf !== 1'b0) begin n_err++; $display("FAIL ovf_fill: got lvl %0d ovf %0d need 8 0", lvl, ovf); end
      end
    end
    n_cmp++; if (lvl !== 4'd8) begin n_err++; $display("FAIL ovf_lvl: got %0d need 8", lvl); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0d need 1", ovf); end
    n_cmp++; if (ovf_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin n_err++; $display("FAIL ovf_cnt: got %0d need %0d", ovf_cnt, CNT_EN ? 2 : 0); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0 || ovf_cnt !== 8'd0 || lvl !== 4'd8) begin
      n_err++; $display("FAIL ovf_clear: got ovf %0d cnt %0d lvl %0d need 0 0 8", ovf, ovf_cnt, lvl); end
  endtask

  task automatic test_full_pass();
    out_rdy = 1'b0;
    lft = 32'hAAAA_0001;
    rgt = 32'hBBBB_0002;
    xfc = 1'b1;
    tick();
    xfc = 1'b0;
    out_rdy = 1'b1;
    tick();
    tick();
    out_rdy = 1'b0;
    tick();
    n_cmp++; if (lvl !== 4'd8 || ovf !== 1'b0) begin n_err++; $display("FAIL full_pass: got lvl %0d ovf %0d need 8 0", lvl, ovf); end
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        n_cmp++; if (out_chan !== 1'b0 || out_data !== 32'hAAAA_0001) begin
          n_err++; $display("FAIL full_pass_l: got chan %0d data %0h need 0 aaaa0001", out_chan, out_data); end
      end
      if (i == 7) begin
        n_cmp++; if (out_chan !== 1'b1 || out_data !== 32'hBBBB_0002) begin
          n_err++; $display("FAIL full_pass_r: got chan %0d data %0h need 1 bbbb0002", out_chan, out_data); end
      end
      tick();
    end
    n_cmp++; if (lvl !== 4'd0) begin n_err++; $display("FAIL full_drain: got %0d need 0", lvl); end
  endtask

  task automatic test_close_strobes();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_rdy = 1'b0;
    lft = 32'h0000_0A0A;
    rgt = 32'h0000_0B0B;
    xfc = 1'b1;
    tick();
    lft = 32'h0000_0C0C;
    rgt = 32'h0000_0D0D;
    tick();
    xfc = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_cmp++; if (lvl !== 4'd2) begin n_err++; $display("FAIL close_lvl: got %0d need 2", lvl); end
    n_cmp++; if (ovf !== 1'b1 || ovf_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
      n_err++; $display("FAIL close_ovf: got ovf %0d cnt %0d need 1 %0d", ovf, ovf_cnt, CNT_EN ? 1 : 0); end
    n_cmp++; if (out_data !== 32'h0A0A || out_chan !== 1'b0) begin
      n_err++; $display("FAIL close_head: got %0h/%0d need a0a/0", out_data, out_chan); end
  endtask

  task automatic test_disable();
    out_rdy = 1'b0;
    xfc = 1'b1;
    tick();
    xfc = 1'b0;
    en = 1'b0;
    tick();
    en = 1'b1;
    n_cmp++; if (lvl !== 4'd0 || out_vld !== 1'b0) begin n_err++; $display("FAIL dis_flush: got lvl %0d vld %0d need 0 0", lvl, out_vld); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL dis_ovf_keep: got %0d need 1", ovf); end
    tick();
    tick();
    n_cmp++; if (lvl !== 4'd0) begin n_err++; $display("FAIL dis_discard: got %0d need 0", lvl); end
  endtask

  task automatic test_rst_mid();
    out_rdy = 1'b0;
    lft = 32'h5555_5555;
    rgt = 32'h6666_6666;
    xfc = 1'b1;
    tick();
    tick();
    xfc = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    xfc = 1'b1;
    tick();
    xfc = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (lvl !== 4'd0 || out_vld !== 1'b0 || ovf !== 1'b0 || ovf_cnt !== 8'd0 || out_data !== 32'd0 || out_chan !== 1'b0) begin
      n_err++; $display("FAIL rst_mid: got lvl %0d vld %0d ovf %0d cnt %0d data %0h chan %0d need all 0", lvl, out_vld, ovf, ovf_cnt, out_data, out_chan); end
    tick();
    tick();
    n_cmp++; if (lvl !== 4'd0) begin n_err++; $display("FAIL rst_mid_discard: got %0d need 0", lvl); end
  endtask

  task automatic test_random();
    int rdy_pct;
    int errs_here;
    errs_here = 0;
    rdy_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) rdy_pct = $urandom_range(0, 100);
      rst     = ($urandom_range(0, 599) == 0);
      en      = ($urandom_range(0, 79) != 0);
      xfc     = ($urandom_range(0, 2) == 0);
      out_rdy = ($urandom_range(0, 99) < rdy_pct);
      ovf_clr = ($urandom_range(0, 99) == 0);
      bist_en = $urandom_range(0, 1);
      lft     = $urandom;
      rgt     = $urandom;
      bist    = $urandom;
      tick();
      n_cmp++; if (lvl !== (AW+1)'(m_q.size())) begin
        n_err++; errs_here++; $display("FAIL rnd_lvl c%0d: got %0d need %0d", c, lvl, m_q.size()); end
      n_cmp++; if (out_vld !== (m_q.size() > 0)) begin
        n_err++; errs_here++; $display("FAIL rnd_vld c%0d: got %0d need %0d", c, out_vld, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        n_cmp++; if ({out_chan, out_data} !== m_q[0]) begin
          n_err++; errs_here++; $display("FAIL rnd_head c%0d: got %0d/%0h need %0d/%0h", c, out_chan, out_data, m_q[0].chan, m_q[0].data); end
      end
      n_cmp++; if (ovf !== m_ovf) begin
        n_err++; errs_here++; $display("FAIL rnd_ovf c%0d: got %0d need %0d", c, ovf, m_ovf); end
      n_cmp++; if (ovf_cnt !== 8'(m_cnt)) begin
        n_err++; errs_here++; $display("FAIL rnd_cnt c%0d: got %0d need %0d", c, ovf_cnt, m_cnt); end
      if (errs_here > 20) break;
    end
    rst = 1'b0; en = 1'b1; xfc = 1'b0; ovf_clr = 1'b0; bist_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
    rst = 1'b1;
    en = 1'b1;
    bist_en = 1'b0;
    ovf_clr = 1'b0;
    xfc = 1'b0;
    lft = '0;
    rgt = '0;
    bist = '0;
    out_rdy = 1'b0;
    test_reset();
    test_deser();
    test_bist();
    test_overflow();
    test_full_pass();
    test_close_strobes();
    test_disable();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2si_src_fifo.md
# i2si_src_fifo

Source select and sample buffer for the I2S input path. Sits directly downstream of the deserializer and the BIST sawtooth generator: on each frame strobe it captures either the deserialized left/right words or the BIST word, writes them as two tagged entries into a small first-word-fall-through FIFO, and presents them to the downstream audio pipeline with a valid/ready handshake. Overflow is detected, flagged sticky, and optionally counted.

## Interface
- DEPTH, 8, FIFO entries; power of two, 4..64
- AW, 3, pointer width, log2(DEPTH)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rf_i2si_en  in  1  block enable; low flushes FIFO and idles FSM
- rf_bist_en  in  1  1 = BIST source, 0 = deserializer source; sampled only on i2si_xfc
- rf_ovf_clr  in  1  one-cycle pulse, clears i2si_ovf (and counter if compiled)
- i2si_xfc  in  1  one-clk frame strobe from deserializer; left/right words valid this cycle
- i2si_lft  in  32  deserialized left word
- i2si_rgt  in  32  deserialized right word
- i2si_bist_out_data  in  32  BIST sawtooth word
- i2si_out_data  out  32  FIFO head data
- i2si_out_chan  out  1  FIFO head channel tag, 0 = left, 1 = right
- i2si_out_vld  out  1  FIFO non-empty
- i2si_out_rdy  in  1  downstream accepts head this cycle
- i2si_fifo_lvl  out  AW+1  current occupancy
- i2si_ovf  out  1  sticky overflow flag
- i2si_ovf_cnt  out  8  saturating drop counter (see Configuration)

## Operation
- Write FSM states: IDLE, WR_L, WR_R.
- IDLE: on i2si_xfc && rf_i2si_en, capture hold_l/hold_r (i2si_lft/i2si_rgt, or i2si_bist_out_data into both when rf_bist_en=1) -> WR_L.
- WR_L: push {chan=0, hold_l} -> WR_R. WR_R: push {chan=1, hold_r} -> IDLE.
- i2si_xfc in WR_L or WR_R: strobe dropped, i2si_ovf set, counter +1; current pair finishes unchanged.
- Push when full (count==DEPTH) and no pop same cycle: entry dropped, i2si_ovf set, counter +1; FSM still advances (left drop does not block right).
- Push when full with simultaneous pop: accepted; count unchanged.
- Pop: i2si_out_vld && i2si_out_rdy; head advances. rdy with empty FIFO ignored.
- i2si_out_data/chan reflect head entry combinationally from storage (FWFT); undefined content ignored while vld=0.
- Pointers AW bits, wrap modulo DEPTH; count AW+1 bits, range 0..DEPTH.
- rf_i2si_en low: next edge pointers/count to 0, FSM to IDLE, in-flight pair discarded; i2si_ovf and counter retained.
- rf_ovf_clr has priority over a same-cycle set: flag and counter read 0 next cycle.

## Timing
- Reset (rst=1 at edge): FSM IDLE, pointers/count 0, i2si_out_vld=0, i2si_fifo_lvl=0, i2si_ovf=0, i2si_ovf_cnt=0, i2si_out_data/chan=0 (storage cleared).
- rst mid-pair: pair discarded, same as above; takes priority over everything.
- i2si_xfc high in cycle T -> WR_L in T+1 -> WR_R in T+2; left entry visible, i2si_out_vld=1 in T+2; right entry written end of T+2.
- Pop in cycle P: i2si_fifo_lvl and head update at P+1.
- Minimum supported xfc spacing 3 clk cycles; closer strobes count as overflow.

## Configuration
- I2SI_OVF_CNT_EN defined: 8-bit drop counter, +1 per dropped entry or dropped strobe, saturates at 255, cleared by rf_ovf_clr or rst.
- Undefined: counter logic absent; i2si_ovf_cnt tied to 8'h00; i2si_ovf unaffected.

## Test plan
- Deserializer mode, rf_bist_en=0, lft=32'h0000_1234, rgt=32'h0000_ABCD, xfc at T, rdy=1 -> out {chan0,0x1234} at T+2, {chan1,0xABCD} at T+3, lvl returns 0.
- BIST mode, bist_out=32'h0000_0100 at xfc -> two entries both 0x100, chan 0 then 1.
- rdy=0, DEPTH=8, five strobes -> lvl 8 after fourth pair, fifth pair both dropped, i2si_ovf=1, ovf_cnt=2; rf_ovf_clr -> both 0, lvl still 8.
- FIFO full, rdy=1 held, xfc -> both entries accepted, lvl stays 8, no overflow.
- xfc at T and T+1 -> second strobe dropped, ovf_cnt=1, exactly two entries written.
- rf_i2si_en low at T+1 after xfc at T -> lvl 0, vld 0 from T+2; rst at T+1 instead -> all outputs reset values at T+2.
